// File: rtl/data_mem_arb_pkg.sv
// Shared definitions for the data memory arbiter: FSM state encoding,
// requester ids and the default memory depth.
package data_mem_arb_pkg;

    // Memory depth in 32-bit words when the parent does not override it.
    localparam int DEPTH_DEFAULT = 1024;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } state_t;

    typedef enum logic {
        REQ_M0 = 1'b0,
        REQ_M1 = 1'b1
    } req_id_t;

endpackage

// File: rtl/data_mem_arbiter_rr_arb2.sv
// rr_arb2: combinational 2-way round-robin pick. The caller owns the
// last-grant pointer and updates it when a pick is actually taken.
module rr_arb2
    import data_mem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic       any,
    output logic       win
);

    // Single requester wins outright; on a tie the one not granted last wins.
    always_comb begin
        any = |req;
        win = REQ_M0;
        case (req)
            2'b01:   win = REQ_M0;
            2'b10:   win = REQ_M1;
            2'b11:   win = (last == REQ_M0) ? REQ_M1 : REQ_M0;
            default: win = REQ_M0;
        endcase
    end

endmodule

// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: shares a single-port word-addressed data memory between
// the core load/store path (m0) and a secondary master (m1). Each access is
// one registered command cycle (ACCESS) followed by a registered response.
// Optional feature: define MEM_ARB_RANGE_CHK_EN to block accesses with
// addr >= DEPTH (no write, read returns 0, err pulses).
module data_mem_arbiter
    import data_mem_arb_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT,
    parameter int AW    = 32,
    parameter int DW    = 32
) (
    input  logic          clk,
    input  logic          rst,

    input  logic          m0_req,
    input  logic          m0_we,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    output logic          m0_gnt,
    output logic          m0_rvalid,
    output logic [DW-1:0] m0_rdata,
    output logic          m0_err,

    input  logic          m1_req,
    input  logic          m1_we,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    output logic          m1_gnt,
    output logic          m1_rvalid,
    output logic [DW-1:0] m1_rdata,
    output logic          m1_err,

    output logic [AW-1:0] mem_A,
    output logic          mem_WE,
    output logic [DW-1:0] mem_WD,
    input  logic [DW-1:0] mem_RD,

    output logic          busy
);

`ifdef MEM_ARB_RANGE_CHK_EN
    localparam logic RANGE_CHK = 1'b1;
`else
    localparam logic RANGE_CHK = 1'b0;
`endif

    state_t          state_q, state_d;

    // Latched command of the current winner.
    logic            cmd_we;
    logic [AW-1:0]   cmd_addr;
    logic [DW-1:0]   cmd_wdata;
    logic            cmd_id;
    logic            cmd_oor;

    // Round-robin pointer: id of the last granted requester.
    logic            last_q;

    logic            arb_any;
    logic            arb_win;

    // Per-requester response registers, indexed by requester id.
    logic [1:0]         rvalid_q;
    logic [1:0]         err_q;
    logic [1:0][DW-1:0] rdata_q;

    // Winner's request fields, muxed ahead of the command latch.
    logic            win_we;
    logic [AW-1:0]   win_addr;
    logic [DW-1:0]   win_wdata;

    rr_arb2 u_arb (
        .req  ({m1_req, m0_req}),
        .last (last_q),
        .any  (arb_any),
        .win  (arb_win)
    );

    assign win_we    = (arb_win == REQ_M1) ? m1_we    : m0_we;
    assign win_addr  = (arb_win == REQ_M1) ? m1_addr  : m0_addr;
    assign win_wdata = (arb_win == REQ_M1) ? m1_wdata : m0_wdata;

    // Out-of-range flag for the latched command; constant 0 when the check is off.
    assign cmd_oor = RANGE_CHK && (cmd_addr >= AW'(DEPTH));

    // State register; async reset aborts any access in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= ST_IDLE;
        else      state_q <= state_d;
    end

    // Next state plus memory drive, decoded from state and latched command only.
    always_comb begin
        state_d = state_q;
        mem_A   = '0;
        mem_WE  = 1'b0;
        mem_WD  = '0;
        case (state_q)
            ST_IDLE: begin
                if (arb_any) state_d = ST_ACCESS;
            end
            ST_ACCESS: begin
                state_d = ST_IDLE;
                mem_A   = cmd_oor ? '0 : cmd_addr;
                mem_WE  = cmd_we & ~cmd_oor;
                mem_WD  = cmd_wdata;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Latch the winner's command and advance the round-robin pointer on accept.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cmd_we    <= 1'b0;
            cmd_addr  <= '0;
            cmd_wdata <= '0;
            cmd_id    <= REQ_M0;
            last_q    <= REQ_M1;
        end else if (state_q == ST_IDLE && arb_any) begin
            cmd_we    <= win_we;
            cmd_addr  <= win_addr;
            cmd_wdata <= win_wdata;
            cmd_id    <= arb_win;
            last_q    <= arb_win;
        end
    end

    // Response stage: capture read data / error at the edge ending ACCESS.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rvalid_q <= '0;
            err_q    <= '0;
            rdata_q  <= '0;
        end else begin
            rvalid_q <= '0;
            err_q    <= '0;
            if (state_q == ST_ACCESS) begin
                err_q[cmd_id] <= cmd_oor;
                if (!cmd_we) begin
                    rvalid_q[cmd_id] <= 1'b1;
                    rdata_q[cmd_id]  <= cmd_oor ? '0 : mem_RD;
                end
            end
        end
    end

    // Grants follow the registered state, so they last exactly the ACCESS cycle.
    assign busy      = (state_q == ST_ACCESS);
    assign m0_gnt    = busy && (cmd_id == REQ_M0);
    assign m1_gnt    = busy && (cmd_id == REQ_M1);

    assign m0_rvalid = rvalid_q[REQ_M0];
    assign m1_rvalid = rvalid_q[REQ_M1];
    assign m0_rdata  = rdata_q[REQ_M0];
    assign m1_rdata  = rdata_q[REQ_M1];
    assign m0_err    = err_q[REQ_M0];
    assign m1_err    = err_q[REQ_M1];

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter with a behavioural single-port memory.
module tb_data_mem_arbiter;

    localparam int DEPTH = 1024;
    localparam int AW    = 32;
    localparam int DW    = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          m0_req = 1'b0, m0_we = 1'b0;
    logic [AW-1:0] m0_addr = '0;
    logic [DW-1:0] m0_wdata = '0;
    logic          m0_gnt, m0_rvalid, m0_err;
    logic [DW-1:0] m0_rdata;
    logic          m1_req = 1'b0, m1_we = 1'b0;
    logic [AW-1:0] m1_addr = '0;
    logic [DW-1:0] m1_wdata = '0;
    logic          m1_gnt, m1_rvalid, m1_err;
    logic [DW-1:0] m1_rdata;
    logic [AW-1:0] mem_A;
    logic          mem_WE;
    logic [DW-1:0] mem_WD;
    logic [DW-1:0] mem_RD;
    logic          busy;

    logic [DW-1:0] mem [0:DEPTH-1];

    int checks   = 0;
    int failures = 0;

    data_mem_arbiter #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_err(m0_err),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_err(m1_err),
        .mem_A(mem_A), .mem_WE(mem_WE), .mem_WD(mem_WD), .mem_RD(mem_RD),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Memory: combinational read, commit on rising edge when WE is high.
    assign mem_RD = (mem_A < AW'(DEPTH)) ? mem[mem_A[9:0]] : 32'hBAD0BAD0;
    always @(posedge clk) if (mem_WE && mem_A < AW'(DEPTH)) mem[mem_A[9:0]] <= mem_WD;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge; sample then drive.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_gnt0"},    m0_gnt,    0);
        chk({tag, "_gnt1"},    m1_gnt,    0);
        chk({tag, "_rvalid0"}, m0_rvalid, 0);
        chk({tag, "_rvalid1"}, m1_rvalid, 0);
        chk({tag, "_err0"},    m0_err,    0);
        chk({tag, "_err1"},    m1_err,    0);
        chk({tag, "_busy"},    busy,      0);
        chk({tag, "_we"},      mem_WE,    0);
        chk({tag, "_A"},       mem_A,     0);
        chk({tag, "_WD"},      mem_WD,    0);
        chk({tag, "_rdata0"},  m0_rdata,  0);
        chk({tag, "_rdata1"},  m1_rdata,  0);
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = '0;
        mem[40] = 32'h0000_0002;
        mem[5]  = 32'hAAAA_5555;

        // Reset state
        tick(); tick();
        chk_all_zero("reset");
        #3 rst = 1'b1;
        tick();

        // m0 write addr 28
        m0_req = 1; m0_we = 1; m0_addr = 28; m0_wdata = 32'hDEADBEEF;
        chk("wr_gnt_t0", m0_gnt, 0);
        tick();
        chk("wr_gnt", m0_gnt, 1);
        chk("wr_busy", busy, 1);
        chk("wr_WE", mem_WE, 1);
        chk("wr_A", mem_A, 28);
        chk("wr_WD", mem_WD, 32'hDEADBEEF);
        chk("wr_gnt1", m1_gnt, 0);
        m0_req = 0;
        tick();
        chk("wr_gnt_end", m0_gnt, 0);
        chk("wr_no_rvalid", m0_rvalid, 0);
        chk("wr_err", m0_err, 0);
        chk("wr_idle_WE", mem_WE, 0);
        chk("wr_mem28", mem[28], 32'hDEADBEEF);

        // m0 read addr 28
        m0_req = 1; m0_we = 0; m0_addr = 28; m0_wdata = 0;
        tick();
        chk("rd_gnt", m0_gnt, 1);
        chk("rd_WE", mem_WE, 0);
        chk("rd_A", mem_A, 28);
        m0_req = 0;
        tick();
        chk("rd_rvalid", m0_rvalid, 1);
        chk("rd_rdata", m0_rdata, 32'hDEADBEEF);
        tick();
        chk("rd_rvalid_pulse", m0_rvalid, 0);
        chk("rd_rdata_held", m0_rdata, 32'hDEADBEEF);

        // m1 preloaded read addr 40
        m1_req = 1; m1_we = 0; m1_addr = 40;
        tick();
        chk("m1rd_gnt", m1_gnt, 1);
        chk("m1rd_gnt0", m0_gnt, 0);
        chk("m1rd_A", mem_A, 40);
        m1_req = 0;
        tick();
        chk("m1rd_rvalid", m1_rvalid, 1);
        chk("m1rd_rdata", m1_rdata, 32'h2);
        chk("m1rd_m0_rvalid", m0_rvalid, 0);
        chk("m1rd_m0_rdata", m0_rdata, 32'hDEADBEEF);

        // Reset asserted mid-write to addr 5
        m0_req = 1; m0_we = 1; m0_addr = 5; m0_wdata = 32'h12345678;
        tick();
        chk("rstwr_WE_before", mem_WE, 1);
        #3 rst = 1'b0;
        #1;
        chk("rstwr_WE_drop", mem_WE, 0);
        chk("rstwr_busy", busy, 0);
        chk("rstwr_gnt", m0_gnt, 0);
        m0_req = 0; m0_we = 0; m0_addr = 0; m0_wdata = 0;
        tick();
        chk("rstwr_mem5", mem[5], 32'hAAAA5555);
        chk_all_zero("rstwr");
        #3 rst = 1'b1;
        tick();

        // Simultaneous reads after reset: m0 first
        m0_req = 1; m0_we = 0; m0_addr = 28;
        m1_req = 1; m1_we = 0; m1_addr = 40;
        tick();
        chk("tie_gnt0", m0_gnt, 1);
        chk("tie_gnt1", m1_gnt, 0);
        m0_req = 0;
        tick();
        chk("tie_rvalid0", m0_rvalid, 1);
        chk("tie_rdata0", m0_rdata, 32'hDEADBEEF);
        chk("tie_gnt1_idle", m1_gnt, 0);
        tick();
        chk("tie_gnt1_late", m1_gnt, 1);
        chk("tie_gnt0_late", m0_gnt, 0);
        m1_req = 0;
        tick();
        chk("tie_rvalid1", m1_rvalid, 1);
        chk("tie_rdata1", m1_rdata, 32'h2);

        // Continuous contention: grants strictly alternate starting with m0
        m0_req = 1; m0_we = 0; m0_addr = 28;
        m1_req = 1; m1_we = 0; m1_addr = 40;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk($sformatf("cont%0d_gnt0", i), m0_gnt, (i % 2 == 0));
            chk($sformatf("cont%0d_gnt1", i), m1_gnt, (i % 2 == 1));
            if (i == 7) begin m0_req = 0; m1_req = 0; end
            tick();
            if (i % 2 == 0) chk($sformatf("cont%0d_rv0", i), m0_rvalid, 1);
            else            chk($sformatf("cont%0d_rv1", i), m1_rvalid, 1);
        end
        tick();
        chk("cont_drained", busy, 0);

`ifdef MEM_ARB_RANGE_CHK_EN
        // Out-of-range write: granted, no memory write, err at t+2
        m0_req = 1; m0_we = 1; m0_addr = 1024; m0_wdata = 32'hCAFEF00D;
        tick();
        chk("oorw_gnt", m0_gnt, 1);
        chk("oorw_WE", mem_WE, 0);
        chk("oorw_A", mem_A, 0);
        m0_req = 0;
        tick();
        chk("oorw_err", m0_err, 1);
        chk("oorw_rvalid", m0_rvalid, 0);
        chk("oorw_WE_after", mem_WE, 0);
        chk("oorw_mem0", mem[0], 0);
        tick();
        chk("oorw_err_pulse", m0_err, 0);

        // Out-of-range read: err and rvalid together, rdata 0
        m1_req = 1; m1_we = 0; m1_addr = 2000;
        tick();
        chk("oorr_gnt", m1_gnt, 1);
        chk("oorr_A", mem_A, 0);
        m1_req = 0;
        tick();
        chk("oorr_err", m1_err, 1);
        chk("oorr_rvalid", m1_rvalid, 1);
        chk("oorr_rdata", m1_rdata, 0);
`else
        // Range check off: address passes through, err stays 0
        m0_req = 1; m0_we = 0; m0_addr = 1024;
        tick();
        chk("pass_gnt", m0_gnt, 1);
        chk("pass_A", mem_A, 1024);
        m0_req = 0;
        tick();
        chk("pass_err", m0_err, 0);
        chk("pass_rvalid", m0_rvalid, 1);
        chk("pass_rdata", m0_rdata, 32'hBAD0BAD0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/data_mem_arbiter.md
# data_mem_arbiter

Two-requester arbiter and sequencer for the single-port, word-addressed data memory. It shares the memory between the core load/store path (m0) and a secondary master such as DMA or debug (m1). Each access is registered: one command stage drives the memory, and one response stage returns read data. The block sits between the requesters and the memory's A/WE/WD/RD pins.

## Interface
- DEPTH, 1024: memory depth in 32-bit words; legal addresses are 0..DEPTH-1.
- AW, 32: address width (word address).
- DW, 32: data width.
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-low reset.
- mN_req  in  1  request (N = 0, 1); held with fields stable until mN_gnt.
- mN_we  in  1  1 = write, 0 = read.
- mN_addr  in  AW  word address.
- mN_wdata  in  DW  write data.
- mN_gnt  out  1  one-cycle pulse; command accepted.
- mN_rvalid  out  1  one-cycle pulse; mN_rdata valid (reads only).
- mN_rdata  out  DW  read data, held until the next read completes.
- mN_err  out  1  one-cycle pulse; out-of-range access (see Configuration).
- mem_A  out  AW  memory address.
- mem_WE  out  1  memory write enable.
- mem_WD  out  DW  memory write data.
- mem_RD  in  DW  memory combinational read data.
- busy  out  1  high while the FSM is in ACCESS.

## Operation
- FSM has two states, IDLE and ACCESS. Reset state is IDLE.
- IDLE: if any mN_req is high, latch the winner's we/addr/wdata and requester id, then go to ACCESS. Otherwise stay in IDLE.
- ACCESS: always returns to IDLE on the next edge.
- Arbitration is 2-way round-robin:
  - Only one requester asserting: that requester wins.
  - Both asserting: the requester not granted last wins.
  - The last-grant pointer resets to m1, so m0 wins the first tie.
- mN_gnt is registered and high for exactly the ACCESS cycle of requester N.
- While in ACCESS, mem_A, mem_WE and mem_WD are driven from the latched command. mem_WE equals the latched we.
- In IDLE: mem_WE=0, mem_A=0, mem_WD=0. These outputs are decoded from state, never from raw requester inputs.
- Reads: mem_RD is sampled at the edge ending ACCESS into the winner's rdata register. mN_rvalid pulses in the following cycle.
- Writes: the memory commits at the edge ending ACCESS. No rvalid is produced.
- Requesters may change fields, or drop req, in the cycle after gnt.
- The non-winning requester keeps req asserted and is served in the next IDLE cycle.

## Timing
- Request sampled in cycle t (IDLE).
- gnt, busy and the memory drive occur in t+1.
- rvalid/rdata, or err, occur in t+2.
- Throughput: one access every 2 cycles. Back-to-back grants alternate between requesters under contention.
- Reset values:
  - gnt, rvalid, err, busy, mem_WE = 0.
  - mem_A, mem_WD, rdata = 0.
  - last-grant pointer = m1.
- Reset asserted during ACCESS: state goes to IDLE immediately and mem_WE drops combinationally, so no write commits. No rvalid is generated for the aborted access.
- Reset has priority over every other event.

## Configuration
- Macro: MEM_ARB_RANGE_CHK_EN.
- Defined: any access with addr ≥ DEPTH is still granted. In ACCESS, mem_WE is forced 0 and mem_A is driven 0.
  - mN_err pulses at t+2.
  - Reads additionally pulse rvalid with rdata = 0.
- Undefined: the address passes through unchecked. mN_err is tied 0 (the ports remain present).

## Structure
- Package data_mem_arb_pkg holds:
  - state encoding (ST_IDLE, ST_ACCESS);
  - requester ids (REQ_M0, REQ_M1);
  - the default DEPTH.
- Sub-module rr_arb2: a combinational 2-way round-robin pick from req[1:0] plus the last pointer. The parent owns the pointer update.

## Test plan
- Write then read on m0: write addr 28 data 0xDEADBEEF, then read addr 28. gnt appears at t+1 for each; rvalid at t+2 with m0_rdata = 0xDEADBEEF.
- Preloaded-value read on m1: read addr 40 on a memory initialised with Data[40] = 0x2. m1_rvalid at t+2 with rdata = 0x00000002; m0 outputs stay idle.
- Simultaneous requests after reset: m0 and m1 both read in the same cycle. m0_gnt comes first; m1_gnt follows 2 cycles later; each rdata matches its own address.
- Continuous contention: both requesters hold req for 8 accesses. Grants strictly alternate m0, m1, m0, …; no requester is starved.
- Reset mid-write: assert rst during the ACCESS cycle of a write of 0x12345678 to addr 5. Addr 5 keeps its prior value, and all outputs read 0 during reset.
- With MEM_ARB_RANGE_CHK_EN: a write to addr 1024 produces err at t+2 and mem_WE stays 0 throughout. A read of addr 2000 produces err and rvalid together with rdata = 0.
